// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
package mult_pkg;

  // Controller states: operand capture, iteration, result hold.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of RUN iterations needed to consume the whole multiplier.
  function automatic int calc_steps(input int width, input int radix_bits);
    return width / radix_bits;
  endfunction

  // Legal configurations: radix of 1, 2 or 4 bits that evenly divides a width of at least 2.
  function automatic bit radix_legal(input int width, input int radix_bits);
    return ((radix_bits == 1) || (radix_bits == 2) || (radix_bits == 4)) &&
           (width >= 2) && ((width % radix_bits) == 0);
  endfunction

endpackage

// File: rtl/mult_step.sv
// Combinational radix step: adds multiplicand x (RADIX_BITS multiplier bits)
// onto the upper accumulator slice. The result is WIDTH+RADIX_BITS bits wide, so it never overflows.
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RADIX_BITS = 1
) (
  input  logic [WIDTH-1:0]            i_acc_slice,
  input  logic [WIDTH-1:0]            i_mcand,
  input  logic [RADIX_BITS-1:0]       i_mbits,
  output logic [WIDTH+RADIX_BITS-1:0] o_sum
);

  localparam int SW = WIDTH + RADIX_BITS;

  logic [SW-1:0] w_pp [RADIX_BITS];

  // One shifted partial product per multiplier bit in this step.
  generate
    for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_pp
      assign w_pp[gi] = i_mbits[gi] ? (SW'(i_mcand) << gi) : '0;
    end
  endgenerate

  // Sum the partial products onto the incoming accumulator slice.
  always_comb begin
    o_sum = SW'(i_acc_slice);
    for (int b = 0; b < RADIX_BITS; b++) begin
      o_sum = o_sum + w_pp[b];
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier with valid/ready on both sides.
// It retires RADIX_BITS multiplier bits per cycle and holds the result until it is accepted.
// Optional feature macro: MULT_SIGNED_EN. It adds the signed_mode port, sign-magnitude
// handling and one extra RUN cycle to negate signed results.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RADIX_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
`ifdef MULT_SIGNED_EN
  input  logic                 signed_mode,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N     = calc_steps(WIDTH, RADIX_BITS);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = PW + RADIX_BITS;

  generate
    if (!radix_legal(WIDTH, RADIX_BITS)) begin : g_bad_cfg
      $error("seq_multiplier: RADIX_BITS must be 1, 2 or 4 and divide WIDTH (WIDTH >= 2)");
    end
  endgenerate

  state_t                  r_state;
  logic [WIDTH-1:0]        r_mplier;
  logic [WIDTH-1:0]        r_mcand;
  logic [PW-1:0]           r_acc;
  logic [PW-1:0]           r_product;
  logic [CNT_W-1:0]        r_cnt;

  logic [WIDTH+RADIX_BITS-1:0] w_sum;
  logic [ACC_W-1:0]            w_acc_wide;
  logic [PW-1:0]               w_acc_next;
  logic [WIDTH-1:0]            w_a_load;
  logic [WIDTH-1:0]            w_b_load;

  // The upper accumulator half absorbs this step's partial product. The whole accumulator then
  // shifts right, so the next step's bits land at the next weight.
  mult_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_step (
    .i_acc_slice (r_acc[PW-1:WIDTH]),
    .i_mcand     (r_mcand),
    .i_mbits     (r_mplier[RADIX_BITS-1:0]),
    .o_sum       (w_sum)
  );

  assign w_acc_wide = {w_sum, r_acc[WIDTH-1:0]};
  assign w_acc_next = PW'(w_acc_wide >> RADIX_BITS);

`ifdef MULT_SIGNED_EN
  logic r_sgn;
  logic r_neg;
  logic r_tail;
  logic w_a_neg;
  logic w_b_neg;

  // Signed operands are iterated as magnitudes. The sign is re-applied in one tail cycle.
  assign w_a_neg  = signed_mode & multiplier[WIDTH-1];
  assign w_b_neg  = signed_mode & multiplicand[WIDTH-1];
  assign w_a_load = w_a_neg ? (~multiplier + WIDTH'(1)) : multiplier;
  assign w_b_load = w_b_neg ? (~multiplicand + WIDTH'(1)) : multiplicand;
`else
  assign w_a_load = multiplier;
  assign w_b_load = multiplicand;
`endif

  // Controller and datapath registers. Asynchronous reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mplier  <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
`ifdef MULT_SIGNED_EN
      r_sgn     <= 1'b0;
      r_neg     <= 1'b0;
      r_tail    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mplier <= w_a_load;
            r_mcand  <= w_b_load;
            r_acc    <= '0;
            r_cnt    <= CNT_W'(N - 1);
            r_state  <= RUN;
`ifdef MULT_SIGNED_EN
            r_sgn    <= signed_mode;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_tail   <= 1'b0;
`endif
          end
        end
        RUN: begin
`ifdef MULT_SIGNED_EN
          if (r_tail) begin
            r_product <= r_neg ? (~r_acc + PW'(1)) : r_acc;
            r_tail    <= 1'b0;
            r_state   <= DONE;
          end else
`endif
          begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> RADIX_BITS;
            if (r_cnt == '0) begin
`ifdef MULT_SIGNED_EN
              if (r_sgn) begin
                r_tail <= 1'b1;
              end else begin
                r_product <= w_acc_next;
                r_state   <= DONE;
              end
`else
              r_product <= w_acc_next;
              r_state   <= DONE;
`endif
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign product   = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomised bench for seq_multiplier over several WIDTH/RADIX_BITS instances.
module tb_seq_multiplier;

  localparam int NI = 5;
  localparam int CW [NI] = '{8, 8, 16, 16, 16};
  localparam int CR [NI] = '{1, 4, 1, 2, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [NI];
  logic        vld  [NI];
  logic        rdy  [NI];
  logic        ordy [NI];
  logic        ov   [NI];
  logic        bsy  [NI];
  logic        sm   [NI];
  logic [15:0] a    [NI];
  logic [15:0] b    [NI];
  logic [31:0] p    [NI];

  int checks   = 0;
  int failures = 0;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      logic [2*CW[gi]-1:0] w_p;
      seq_multiplier #(
        .WIDTH      (CW[gi]),
        .RADIX_BITS (CR[gi])
      ) u_dut (
        .clk          (clk),
        .rst_n        (rstn[gi]),
        .in_valid     (vld[gi]),
        .in_ready     (rdy[gi]),
        .multiplier   (a[gi][CW[gi]-1:0]),
        .multiplicand (b[gi][CW[gi]-1:0]),
`ifdef MULT_SIGNED_EN
        .signed_mode  (sm[gi]),
`endif
        .out_valid    (ov[gi]),
        .out_ready    (ordy[gi]),
        .product      (w_p),
        .busy         (bsy[gi])
      );
      assign p[gi] = 32'(w_p);
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One complete transaction. It starts and ends at a falling edge and re-accepts at full rate.
  task automatic do_op(input int k, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ism, input logic [31:0] exp_p, input int exp_lat,
                       input string name);
    int lat;
    int wt;
    wt = 0;
    while (!rdy[k] && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    chk({name, " in_ready"}, 32'(rdy[k]), 32'd1);
    a[k] = ia; b[k] = ib; sm[k] = ism; vld[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[k] = 1'b0;
    chk({name, " busy"}, 32'(bsy[k]), 32'd1);
    lat = 1;
    while (!ov[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " product"}, p[k], exp_p);
    $display("op dut%0d %h x %h sm=%0d -> %h lat=%0d", k, ia, ib, ism, p[k], lat);
    ordy[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[k] = 1'b0;
    chk({name, " out_valid drop"}, 32'(ov[k]), 32'd0);
  endtask

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] p;
    int          lat;
  } vec_t;

  initial begin
    vec_t vt[$];
    int   wt;

    for (int i = 0; i < NI; i++) begin
      rstn[i] = 1'b0; vld[i] = 1'b0; ordy[i] = 1'b0;
      a[i] = '0; b[i] = '0; sm[i] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst%0d in_ready", i), 32'(rdy[i]), 32'd0);
      chk($sformatf("rst%0d out_valid", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst%0d product", i), p[i], 32'd0);
      chk($sformatf("rst%0d busy", i), 32'(bsy[i]), 32'd0);
      rstn[i] = 1'b1;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rel%0d in_ready", i), 32'(rdy[i]), 32'd1);
    end
    @(negedge clk);

    // Directed vectors: {dut, a, b, signed, product, latency}
    vt.push_back('{0, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, 9});
    vt.push_back('{0, 16'h0000, 16'h0000, 1'b0, 32'h00000000, 9});
    vt.push_back('{0, 16'h000D, 16'h000B, 1'b0, 32'h0000008F, 9});
    vt.push_back('{1, 16'h000D, 16'h000B, 1'b0, 32'h0000008F, 3});
    vt.push_back('{1, 16'h0000, 16'h00AB, 1'b0, 32'h00000000, 3});
    vt.push_back('{1, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, 3});
    vt.push_back('{2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 17});
    vt.push_back('{3, 16'h1234, 16'h5678, 1'b0, 32'h06260060, 9});
    vt.push_back('{4, 16'h8000, 16'h0002, 1'b0, 32'h00010000, 5});
`ifdef MULT_SIGNED_EN
    vt.push_back('{0, 16'h0080, 16'h0080, 1'b1, 32'h00004000, 10});
    vt.push_back('{0, 16'h00FF, 16'h0001, 1'b1, 32'h0000FFFF, 10});
    vt.push_back('{1, 16'h00FE, 16'h0003, 1'b1, 32'h0000FFFA, 4});
    vt.push_back('{0, 16'h0005, 16'h0003, 1'b1, 32'h0000000F, 10});
    vt.push_back('{0, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, 9});
`endif
    foreach (vt[i]) begin
      do_op(vt[i].k, vt[i].a, vt[i].b, vt[i].sm, vt[i].p, vt[i].lat,
            $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 20 cycles while in_valid pulses are ignored
    a[1] = 16'h0012; b[1] = 16'h0034; sm[1] = 1'b0; vld[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[1] = 1'b0;
    wt = 0;
    while (!ov[1] && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    chk("stall reached out_valid", 32'(ov[1]), 32'd1);
    for (int c = 0; c < 20; c++) begin
      chk("stall product", p[1], 32'h000003A8);
      chk("stall out_valid", 32'(ov[1]), 32'd1);
      chk("stall in_ready", 32'(rdy[1]), 32'd0);
      vld[1] = ~vld[1];
      a[1] = 16'h00FF; b[1] = 16'h0077;
      @(negedge clk);
    end
    vld[1] = 1'b0;
    $display("op dut1 stall 0012 x 0034 held -> %h", p[1]);
    ordy[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("post-stall no queued op", 32'(ov[1]), 32'd0);
      chk("post-stall idle", 32'(bsy[1]), 32'd0);
      @(negedge clk);
    end

    // Reset in the middle of RUN
    a[0] = 16'h00FF; b[0] = 16'h0002; sm[0] = 1'b0; vld[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (3) begin
      chk("pre-reset out_valid", 32'(ov[0]), 32'd0);
      @(negedge clk);
    end
    rstn[0] = 1'b0;
    #1;
    chk("midrun rst out_valid", 32'(ov[0]), 32'd0);
    chk("midrun rst product", p[0], 32'd0);
    chk("midrun rst busy", 32'(bsy[0]), 32'd0);
    chk("midrun rst in_ready", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    rstn[0] = 1'b1;
    #1;
    chk("midrun rel in_ready", 32'(rdy[0]), 32'd1);
    chk("midrun rel busy", 32'(bsy[0]), 32'd0);
    $display("op dut0 00ff x 0002 aborted by reset");
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      chk("aborted op silent", 32'(ov[0]), 32'd0);
      @(negedge clk);
    end
    do_op(0, 16'h0003, 16'h0005, 1'b0, 32'h0000000F, 9, "post-reset");

    // Randomised back-to-back ops on the 16-bit instances
    for (int k = 2; k < NI; k++) begin
      for (int n = 0; n < 400; n++) begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        longint      ref_p;
        ra = 16'($urandom);
        rb = 16'($urandom);
        if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h8000;
        if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
        rs = 1'b0;
`ifdef MULT_SIGNED_EN
        rs = 1'($urandom_range(0, 1));
`endif
        if (rs)
          ref_p = longint'($signed(ra)) * longint'($signed(rb));
        else
          ref_p = longint'(ra) * longint'(rb);
        do_op(k, ra, rb, rs, ref_p[31:0], CW[k] / CR[k] + 1 + int'(rs),
              $sformatf("rnd%0d_%0d", k, n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", failures);
    $fatal(1, "watchdog expired");
  end

endmodule
